sdram_frame_rd_ctrl: RTL and testbench
======================================

Name: sdram_frame_rd_ctrl

Overview:
- Per-frame read sequencer and pixel streamer on the user side of the SDRAM read port.
- On each frame trigger it selects the ping-pong frame buffer not being written and issues a port read start with base address and length.
- It then pulls pixels from the port's FWFT FIFO into a registered ready/valid pixel stream with line/frame markers, and flags FIFO underflow.
- Sits between the read port (port-clock side) and the display/ISP pipeline.

Parameters:
- DATA_DW, 16, pixel width; equals the read port's user data width.
- SDRAM_ADDRS_WIDE, 21, SDRAM address / length width.
- H_ACTIVE, 256, pixels per line.
- V_ACTIVE, 192, lines per frame.
- FRAME_BASE0, 21'h000000, SDRAM base address of buffer 0.
- FRAME_BASE1, 21'h010000, SDRAM base address of buffer 1.
- START_HOLD, 4, cycles that o_port_rd_start is held high (min 2, for cross-domain edge detect).

Ports:
- i_port_rd_clk  in  1  single clock; the read port's user clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_frame_start  in  1  single-cycle frame trigger (vsync-derived).
- i_wr_bank  in  1  bank currently being written by the writer; read bank = ~i_wr_bank, sampled on trigger.
- o_port_rd_start  out  1  read start level pulse to the port.
- o_port_rd_addrs  out  SDRAM_ADDRS_WIDE  frame base address.
- o_port_rd_length  out  SDRAM_ADDRS_WIDE  frame length in pixels, H_ACTIVE*V_ACTIVE.
- i_port_rd_data_ready  in  1  port FIFO non-empty.
- i_port_rd_data  in  DATA_DW  FWFT FIFO head.
- o_port_rd_data_req  out  1  FIFO pop (combinational).
- o_pix_data  out  DATA_DW  pixel.
- o_pix_vld  out  1  pixel valid.
- i_pix_ready  in  1  downstream ready.
- o_pix_sof  out  1  qualifies first pixel of frame.
- o_pix_eol  out  1  qualifies last pixel of line.
- o_pix_eof  out  1  qualifies last pixel of frame.
- o_busy  out  1  state != IDLE.
- o_underflow  out  1  sticky underflow flag; cleared by reset or the next i_frame_start.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; bank register 0.
- States:
  - IDLE: on i_frame_start -> START.
  - START: o_port_rd_start=1 for exactly START_HOLD cycles, then -> WAIT_RDY.
  - WAIT_RDY: wait for i_port_rd_data_ready=1 -> STREAM. No pops before this.
  - STREAM: after the last pixel is accepted downstream -> IDLE.
- On trigger:
  - Latch rd_bank = ~i_wr_bank.
  - o_port_rd_addrs = FRAME_BASE1 if rd_bank, else FRAME_BASE0.
  - o_port_rd_length = H_ACTIVE*V_ACTIVE, truncated to SDRAM_ADDRS_WIDE.
  - Both are registered and stable from the first start cycle until the next trigger.
- Pop rule: o_port_rd_data_req = (state==STREAM) && i_port_rd_data_ready && (pix_left!=0) && (!o_pix_vld || i_pix_ready).
- On pop:
  - o_pix_data <= i_port_rd_data; o_pix_vld <= 1.
  - sof/eol/eof are computed from h_cnt/v_cnt of the popped pixel.
  - h_cnt wraps at H_ACTIVE-1 and increments v_cnt.
  - pix_left decrements by 1.
- Without a pop, when o_pix_vld && i_pix_ready: o_pix_vld <= 0. Data and markers hold while vld=1 and ready=0.
- Latency: FIFO head to o_pix_vld is 1 cycle. Full throughput is 1 pixel/clock while FIFO and sink are ready.
- Underflow: in STREAM with pix_left!=0, sink able to accept (!o_pix_vld || i_pix_ready) and i_port_rd_data_ready=0 -> o_underflow <= 1. The stream stalls (no pad data) and resumes when ready returns.
- i_frame_start in any non-IDLE state aborts the current frame:
  - Counters cleared, o_pix_vld cleared same edge, new bank latched, -> START.
  - The read port flushes its FIFO on the new start.
- i_frame_start coincident with the last accepted pixel: the restart wins.
- Synchronous reset mid-frame: immediate return to IDLE; o_port_rd_start drops next edge.

Optional Feature:
- Macro: FRAME_RD_UNDERFLOW_CNT_EN.
- Defined: adds output o_underflow_cnt [15:0].
  - Counts every cycle the underflow condition holds.
  - Saturates at 16'hFFFF.
  - Cleared on reset and on each i_frame_start.
- Undefined: port and counter absent; only the sticky o_underflow exists.

Test Plan (H_ACTIVE=4, V_ACTIVE=2):
- Reset, i_wr_bank=0, pulse i_frame_start -> rd_start high 4 cycles, addrs=FRAME_BASE1, length=8; after ready, pixels 0..7 emitted.
  - sof on pixel 0; eol on pixels 3 and 7; eof on pixel 7; then IDLE, o_busy=0.
- i_wr_bank=1 trigger -> addrs=FRAME_BASE0.
- i_pix_ready toggled 1/0 each cycle, FIFO always ready -> 8 pixels in order, none dropped or duplicated; data held while ready=0; req never asserted while stalled.
- data_ready dropped for 3 cycles after pixel 2 with sink ready -> o_underflow=1; o_underflow_cnt=3 (macro defined); pixels 3..7 still delivered.
- Trigger mid-frame after pixel 5 -> o_pix_vld low next cycle, new rd_start, next frame starts at pixel 0 with sof; o_underflow cleared.
- Reset asserted during STREAM -> all outputs 0 next edge; a following trigger runs a clean full frame.

Source files
------------

// File: rtl/sdram_frame_rd_ctrl_if.sv
// Read-port bus between the frame read controller and the SDRAM read port.
// master: the frame read controller (issues start/address/length and pops).
// slave : the SDRAM read port (presents the FWFT FIFO head and non-empty flag).
interface sdram_frame_rd_ctrl_if #(
    parameter int DATA_DW          = 16,
    parameter int SDRAM_ADDRS_WIDE = 21
);
    logic                        port_rd_start;
    logic [SDRAM_ADDRS_WIDE-1:0] port_rd_addrs;
    logic [SDRAM_ADDRS_WIDE-1:0] port_rd_length;
    logic                        port_rd_data_ready;
    logic [DATA_DW-1:0]          port_rd_data;
    logic                        port_rd_data_req;

    modport master (
        output port_rd_start,
        output port_rd_addrs,
        output port_rd_length,
        output port_rd_data_req,
        input  port_rd_data_ready,
        input  port_rd_data
    );

    modport slave (
        input  port_rd_start,
        input  port_rd_addrs,
        input  port_rd_length,
        input  port_rd_data_req,
        output port_rd_data_ready,
        output port_rd_data
    );
endinterface

// File: rtl/sdram_frame_rd_ctrl.sv
// Per-frame SDRAM read sequencer and pixel streamer.
// On each frame trigger it picks the ping-pong buffer not being written,
// holds a read start to the port, then moves pixels from the port's FWFT
// FIFO into a registered ready/valid stream with sof/eol/eof markers.
// Optional feature macro: FRAME_RD_UNDERFLOW_CNT_EN adds o_underflow_cnt,
// a saturating count of underflow cycles for the current frame.
module sdram_frame_rd_ctrl #(
    parameter int                          DATA_DW          = 16,
    parameter int                          SDRAM_ADDRS_WIDE = 21,
    parameter int                          H_ACTIVE         = 256,
    parameter int                          V_ACTIVE         = 192,
    parameter logic [SDRAM_ADDRS_WIDE-1:0] FRAME_BASE0      = 21'h000000,
    parameter logic [SDRAM_ADDRS_WIDE-1:0] FRAME_BASE1      = 21'h010000,
    parameter int                          START_HOLD       = 4
) (
    input  logic                   i_port_rd_clk,
    input  logic                   i_rst_n,
    input  logic                   i_frame_start,
    input  logic                   i_wr_bank,
    sdram_frame_rd_ctrl_if.master  rd_port,
    output logic [DATA_DW-1:0]     o_pix_data,
    output logic                   o_pix_vld,
    input  logic                   i_pix_ready,
    output logic                   o_pix_sof,
    output logic                   o_pix_eol,
    output logic                   o_pix_eof,
`ifdef FRAME_RD_UNDERFLOW_CNT_EN
    output logic [15:0]            o_underflow_cnt,
`endif
    output logic                   o_busy,
    output logic                   o_underflow
);

    localparam int PIX_TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int LEFT_W    = $clog2(PIX_TOTAL + 1);
    localparam int H_W       = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int V_W       = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int HOLD_W    = $clog2(START_HOLD);

    localparam logic [SDRAM_ADDRS_WIDE-1:0] FRAME_LEN  = SDRAM_ADDRS_WIDE'(PIX_TOTAL);
    localparam logic [LEFT_W-1:0]           LEFT_INIT  = LEFT_W'(PIX_TOTAL);
    localparam logic [H_W-1:0]              H_LAST     = H_W'(H_ACTIVE - 1);
    localparam logic [V_W-1:0]              V_LAST     = V_W'(V_ACTIVE - 1);
    localparam logic [HOLD_W-1:0]           HOLD_LAST  = HOLD_W'(START_HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_RDY,
        ST_STREAM
    } state_e;

    state_e                      state_q, state_d;
    logic [HOLD_W-1:0]           hold_q;
    logic [H_W-1:0]              h_cnt_q;
    logic [V_W-1:0]              v_cnt_q;
    logic [LEFT_W-1:0]           pix_left_q;
    logic [SDRAM_ADDRS_WIDE-1:0] addrs_q;
    logic [SDRAM_ADDRS_WIDE-1:0] length_q;

    logic sink_free;
    logic pop;
    logic underflow_hit;

    // The output register can take a new pixel when empty or being drained.
    assign sink_free = !o_pix_vld || i_pix_ready;

    assign rd_port.port_rd_start    = (state_q == ST_START);
    assign rd_port.port_rd_addrs    = addrs_q;
    assign rd_port.port_rd_length   = length_q;
    assign rd_port.port_rd_data_req = pop;
    assign o_busy                   = (state_q != ST_IDLE);

    // State register.
    // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
    always_ff @(posedge i_port_rd_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, pop and underflow decode; a frame trigger overrides every state.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d       = state_q;
        pop           = 1'b0;
        underflow_hit = 1'b0;
        unique case (state_q)
            ST_IDLE: ;
            ST_START: begin
                if (hold_q == HOLD_LAST) state_d = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
                if (rd_port.port_rd_data_ready) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                pop           = rd_port.port_rd_data_ready && (pix_left_q != '0) && sink_free;
                underflow_hit = !rd_port.port_rd_data_ready && (pix_left_q != '0) && sink_free;
                if ((pix_left_q == '0) && sink_free) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (i_frame_start) state_d = ST_START;
    end

    // Frame setup, raster counters, registered pixel output and sticky underflow.
    always_ff @(posedge i_port_rd_clk) begin
        if (!i_rst_n) begin
            hold_q      <= '0;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            pix_left_q  <= '0;
            addrs_q     <= '0;
            length_q    <= '0;
            o_pix_data  <= '0;
            o_pix_vld   <= 1'b0;
            o_pix_sof   <= 1'b0;
            o_pix_eol   <= 1'b0;
            o_pix_eof   <= 1'b0;
            o_underflow <= 1'b0;
        end else if (i_frame_start) begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            addrs_q     <= i_wr_bank ? FRAME_BASE0 : FRAME_BASE1;
            length_q    <= FRAME_LEN;
            hold_q      <= '0;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            pix_left_q  <= LEFT_INIT;
            o_pix_vld   <= 1'b0;
            o_pix_sof   <= 1'b0;
            o_pix_eol   <= 1'b0;
            o_pix_eof   <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (state_q == ST_START) hold_q <= hold_q + HOLD_W'(1);
            if (pop) begin
                o_pix_data <= rd_port.port_rd_data;
                o_pix_vld  <= 1'b1;
                o_pix_sof  <= (h_cnt_q == '0) && (v_cnt_q == '0);
                o_pix_eol  <= (h_cnt_q == H_LAST);
                o_pix_eof  <= (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
                pix_left_q <= pix_left_q - LEFT_W'(1);
                if (h_cnt_q == H_LAST) begin
                    h_cnt_q <= '0;
                    v_cnt_q <= v_cnt_q + V_W'(1);
                end else begin
                    h_cnt_q <= h_cnt_q + H_W'(1);
                end
            end else if (o_pix_vld && i_pix_ready) begin
                o_pix_vld <= 1'b0;
            end
            if (underflow_hit) o_underflow <= 1'b1;
        end
    end

`ifdef FRAME_RD_UNDERFLOW_CNT_EN
    // Saturating per-frame count of cycles spent in the underflow condition.
    always_ff @(posedge i_port_rd_clk) begin
        if (!i_rst_n || i_frame_start) begin
            o_underflow_cnt <= '0;
        end else if (underflow_hit && (o_underflow_cnt != 16'hFFFF)) begin
            o_underflow_cnt <= o_underflow_cnt + 16'd1;
        end
    end
`else
    // Only the sticky o_underflow flag reports FIFO starvation in this build.
`endif

endmodule

// File: tb/tb_sdram_frame_rd_ctrl.sv
// Self-checking bench for sdram_frame_rd_ctrl (H_ACTIVE=4, V_ACTIVE=2).
// The bench plays the read port: a queue stands in for the FWFT FIFO and is
// refilled on every frame trigger; a second queue holds the expected pixel
// stream (data plus markers derived from the pixel index) and is consumed on
// every downstream handshake.
// Optional feature macro: FRAME_RD_UNDERFLOW_CNT_EN enables o_underflow_cnt checks.
module tb_sdram_frame_rd_ctrl;

    localparam int          DW    = 16;
    localparam int          AW    = 21;
    localparam int          H     = 4;
    localparam int          V     = 2;
    localparam int          NPIX  = H * V;
    localparam int          HOLD  = 4;
    localparam logic [20:0] BASE0 = 21'h000000;
    localparam logic [20:0] BASE1 = 21'h010000;
    localparam int          FRAME_BUDGET = 400;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sof;
        logic          eol;
        logic          eof;
    } pix_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_start;
    logic          wr_bank;
    logic          pix_ready;
    logic [DW-1:0] pix_data;
    logic          pix_vld;
    logic          pix_sof;
    logic          pix_eol;
    logic          pix_eof;
    logic          busy;
    logic          underflow;
`ifdef FRAME_RD_UNDERFLOW_CNT_EN
    logic [15:0]   underflow_cnt;
`endif

    sdram_frame_rd_ctrl_if #(.DATA_DW(DW), .SDRAM_ADDRS_WIDE(AW)) rd_bus ();

    sdram_frame_rd_ctrl #(
        .DATA_DW          (DW),
        .SDRAM_ADDRS_WIDE (AW),
        .H_ACTIVE         (H),
        .V_ACTIVE         (V),
        .FRAME_BASE0      (BASE0),
        .FRAME_BASE1      (BASE1),
        .START_HOLD       (HOLD)
    ) dut (
        .i_port_rd_clk   (clk),
        .i_rst_n         (rst_n),
        .i_frame_start   (frame_start),
        .i_wr_bank       (wr_bank),
        .rd_port         (rd_bus),
        .o_pix_data      (pix_data),
        .o_pix_vld       (pix_vld),
        .i_pix_ready     (pix_ready),
        .o_pix_sof       (pix_sof),
        .o_pix_eol       (pix_eol),
        .o_pix_eof       (pix_eof),
`ifdef FRAME_RD_UNDERFLOW_CNT_EN
        .o_underflow_cnt (underflow_cnt),
`endif
        .o_busy          (busy),
        .o_underflow     (underflow)
    );

    always #5 clk = ~clk;

    // Bench-side model state.
    logic [DW-1:0] fifo_q[$];
    pix_t          exp_q[$];
    logic          fifo_gate;
    logic [20:0]   exp_addr;
    int            start_cnt;
    int            pops;
    int            accepts;
    bit            check_idle;
    bit            trig_seen;
    bit            prev_stall;
    pix_t          prev_pix;
    int            n_checks;
    int            n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Fill the port FIFO with a fresh random frame and derive the expected stream.
    task automatic load_frame();
        pix_t p;
        fifo_q.delete();
        exp_q.delete();
        for (int i = 0; i < NPIX; i++) begin
            p.data = DW'($urandom);
            p.sof  = (i == 0);
            p.eol  = ((i % H) == H - 1);
            p.eof  = (i == NPIX - 1);
            fifo_q.push_back(p.data);
            exp_q.push_back(p);
        end
    endtask

    // One clock cycle: drive port inputs, observe outputs, update the model, advance.
    task automatic step();
        pix_t got;
        pix_t e;
        rd_bus.port_rd_data_ready = fifo_gate && (fifo_q.size() != 0);
        rd_bus.port_rd_data       = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        #1;
        got = '{data: pix_data, sof: pix_sof, eol: pix_eol, eof: pix_eof};
        if (rst_n) begin
            if (trig_seen) begin
                check("trig_vld_clear", pix_vld, 0);
                check("trig_underflow_clear", underflow, 0);
`ifdef FRAME_RD_UNDERFLOW_CNT_EN
                check("trig_ucnt_clear", underflow_cnt, 0);
`endif
                trig_seen = 0;
            end
            if (check_idle) begin
                check("idle_busy", busy, 0);
                check("idle_vld", pix_vld, 0);
                check_idle = 0;
            end
            if (prev_stall) begin
                check("stall_hold_vld", pix_vld, 1);
                check("stall_hold_pix", got, prev_pix);
            end
            if (pix_vld && !pix_ready) check("no_req_while_stalled", rd_bus.port_rd_data_req, 0);
            if (rd_bus.port_rd_start) begin
                start_cnt++;
                check("rd_addrs", rd_bus.port_rd_addrs, exp_addr);
                check("rd_length", rd_bus.port_rd_length, NPIX);
            end else if (start_cnt != 0) begin
                check("rd_start_cycles", start_cnt, HOLD);
                start_cnt = 0;
            end
            if (rd_bus.port_rd_data_req) begin
                check("req_needs_ready", rd_bus.port_rd_data_ready, 1);
                pops++;
                if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            end
            if (pix_vld && pix_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_pixel", pix_vld, 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("pixel%0d", accepts), got, e);
                    accepts++;
                    if (exp_q.size() == 0 && !frame_start) check_idle = 1;
                end
            end
            prev_stall = pix_vld && !pix_ready;
            prev_pix   = got;
        end
        if (frame_start) begin
            load_frame();
            exp_addr   = wr_bank ? BASE0 : BASE1;
            start_cnt  = 0;
            prev_stall = 0;
            check_idle = 0;
            trig_seen  = rst_n;
        end
        if (!rst_n) begin
            fifo_q.delete();
            exp_q.delete();
            start_cnt  = 0;
            prev_stall = 0;
            check_idle = 0;
            trig_seen  = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_rd_start", rd_bus.port_rd_start, 0);
        check("rst_rd_addrs", rd_bus.port_rd_addrs, 0);
        check("rst_rd_length", rd_bus.port_rd_length, 0);
        check("rst_rd_req", rd_bus.port_rd_data_req, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_pix_vld", pix_vld, 0);
        check("rst_markers", {pix_sof, pix_eol, pix_eof}, 0);
        check("rst_busy", busy, 0);
        check("rst_underflow", underflow, 0);
`ifdef FRAME_RD_UNDERFLOW_CNT_EN
        check("rst_ucnt", underflow_cnt, 0);
`endif
    endtask

    // rdy_mode: 0 sink always ready, 1 toggle, 2 random.
    // gap_mode: 0 FIFO always ready, 1 random gaps, 2 three-cycle gap after pixel 2.
    // abort_at: return early once this many pixels were accepted (-1 = run to end).
    task automatic run_frame(input logic wr, input int rdy_mode, input int gap_mode,
                             input int abort_at);
        int  cyc;
        int  gap_left;
        bit  gap_done;
        wr_bank     = wr;
        pix_ready   = 1'b1;
        fifo_gate   = 1'b1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        accepts  = 0;
        pops     = 0;
        gap_left = 0;
        gap_done = 0;
        cyc      = 0;
        while (exp_q.size() != 0 && cyc < FRAME_BUDGET) begin
            if (abort_at >= 0 && accepts >= abort_at) return;
            case (rdy_mode)
                1:       pix_ready = cyc[0];
                2:       pix_ready = ($urandom_range(0, 2) != 0);
                default: pix_ready = 1'b1;
            endcase
            case (gap_mode)
                1: fifo_gate = ($urandom_range(0, 3) != 0);
                2: begin
                    if (pops == 3 && !gap_done) begin
                        gap_left = 3;
                        gap_done = 1;
                    end
                    fifo_gate = (gap_left == 0);
                    if (gap_left > 0) gap_left--;
                end
                default: fifo_gate = 1'b1;
            endcase
            step();
            cyc++;
        end
        if (cyc >= FRAME_BUDGET) check("frame_timeout_pixels_left", exp_q.size(), 0);
        pix_ready = 1'b1;
        fifo_gate = 1'b1;
        step();
        check("frame_accept_count", accepts, NPIX);
        if (gap_mode == 0) check("no_underflow", underflow, 0);
        if (gap_mode == 2) begin
            check("underflow_flag", underflow, 1);
`ifdef FRAME_RD_UNDERFLOW_CNT_EN
            check("underflow_cnt", underflow_cnt, 3);
`endif
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        start_cnt   = 0;
        pops        = 0;
        accepts     = 0;
        check_idle  = 0;
        trig_seen   = 0;
        prev_stall  = 0;
        prev_pix    = '0;
        exp_addr    = '0;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        wr_bank     = 1'b0;
        pix_ready   = 1'b0;
        fifo_gate   = 1'b0;
        rd_bus.port_rd_data_ready = 1'b0;
        rd_bus.port_rd_data       = '0;

        // Reset state.
        repeat (3) step();
        check_reset_outputs();
        rst_n = 1'b1;
        step();

        // Plain frames from each bank, full throughput.
        run_frame(1'b0, 0, 0, -1);
        run_frame(1'b1, 0, 0, -1);

        // Sink toggling ready every cycle.
        run_frame(1'b0, 1, 0, -1);

        // FIFO starvation for three cycles after pixel 2.
        run_frame(1'b1, 0, 2, -1);

        // Abort after pixel 5 of a frame that has already underflowed.
        run_frame(1'b0, 0, 2, 6);
        check("pre_abort_underflow", underflow, 1);
        check("pre_abort_busy", busy, 1);
        run_frame(1'b1, 0, 0, -1);

        // Synchronous reset in the middle of streaming, then a clean frame.
        run_frame(1'b0, 0, 0, 3);
        rst_n = 1'b0;
        step();
        check_reset_outputs();
        rst_n = 1'b1;
        step();
        run_frame(1'b0, 0, 0, -1);

        // Randomized frames: random bank, sink ready and FIFO availability.
        for (int f = 0; f < 8; f++) begin
            run_frame(1'($urandom_range(0, 1)), 2, 1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
